// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, FSM states and word helpers.
package aes_pkg;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned KEY_W         = 128;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned ROUND_W       = 4;

    // Round constants, indexed by the round being produced (1..10).
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        EMIT = 2'd2
    } state_e;

    // Left byte rotate of a key word.
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Guarded round-constant lookup; rounds outside 1..10 yield 0.
    function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] r);
        logic [7:0] v;
        v = 8'h00;
        if ((r >= 4'd1) && (r <= 4'd10)) begin
            v = RCON[r];
        end
        return v;
    endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Key-load and round-key stream bus of the inverse key scheduler.
interface aes_inv_key_sched_if;
    import aes_pkg::*;

    logic                 key_valid;
    logic                 key_ready;
    logic [KEY_W-1:0]     key_in;
    logic                 key_is_last;
    logic                 rk_valid;
    logic                 rk_ready;
    logic [KEY_W-1:0]     rk_data;
    logic [ROUND_W-1:0]   rk_round;
    logic                 rk_last;
    logic                 busy;

    // Key source and round-key consumer side.
    modport master (
        output key_valid, key_in, key_is_last, rk_ready,
        input  key_ready, rk_valid, rk_data, rk_round, rk_last, busy
    );

    // Scheduler side.
    modport slave (
        input  key_valid, key_in, key_is_last, rk_ready,
        output key_ready, rk_valid, rk_data, rk_round, rk_last, busy
    );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [7:0] INV_EXP = 8'hfe;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] pw;
        r  = 8'h01;
        pw = a;
        for (int i = 0; i < 8; i++) begin
            if (INV_EXP[i]) begin
                r = gf_mul(r, pw);
            end
            pw = gf_mul(pw, pw);
        end
        return r;
    endfunction

    logic [7:0] inv_b;

    // Inverse then affine transform with constant 0x63.
    always_comb begin
        inv_b = gf_inv(in_i);
        out_o = inv_b
              ^ {inv_b[6:0], inv_b[7]}
              ^ {inv_b[5:0], inv_b[7:6]}
              ^ {inv_b[4:0], inv_b[7:5]}
              ^ {inv_b[3:0], inv_b[7:4]}
              ^ 8'h63;
    end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 decryption key scheduler: expands forward to round 10, then
// regenerates and streams round keys 10..0 one per handshake.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int unsigned ROUNDS  = 10,
    parameter bit          ZEROIZE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    aes_inv_key_sched_if.slave bus
);

    if (ROUNDS != AES128_ROUNDS) begin : g_rounds_chk
        $error("aes_inv_key_sched: only ROUNDS=10 (AES-128) is supported");
    end

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);
    localparam logic [ROUND_W-1:0] PRE_LAST   = ROUND_W'(ROUNDS - 1);

    state_e               state_q;
    logic [ROUND_W-1:0]   round_q;
    logic [KEY_W-1:0]     key_q;
    logic                 key_ready_q;
    logic                 rk_valid_q;
    logic                 rk_last_q;
    logic                 busy_q;

    logic [WORD_W-1:0]    k0, k1, k2, k3;
    logic [WORD_W-1:0]    sub_in_c, sub_out_c, t_c;
    logic [ROUND_W-1:0]   step_round_c;
    logic [KEY_W-1:0]     fwd_key_c, inv_key_c;

    assign k0 = key_q[127:96];
    assign k1 = key_q[95:64];
    assign k2 = key_q[63:32];
    assign k3 = key_q[31:0];

    // Single SubWord shared by the forward and inverse steps via an input mux.
    always_comb begin
        step_round_c = round_q;
        sub_in_c     = rot_word(k3 ^ k2);
        if (state_q == FWD) begin
            step_round_c = ROUND_W'(round_q + 4'd1);
            sub_in_c     = rot_word(k3);
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (sub_in_c[8*b +: 8]),
            .out_o (sub_out_c[8*b +: 8])
        );
    end

    // Next round key (forward) and previous round key (inverse).
    always_comb begin
        logic [WORD_W-1:0] n0, n1, n2, n3;
        t_c       = sub_out_c ^ {rcon(step_round_c), 24'h000000};
        n0        = k0 ^ t_c;
        n1        = k1 ^ n0;
        n2        = k2 ^ n1;
        n3        = k3 ^ n2;
        fwd_key_c = {n0, n1, n2, n3};
        inv_key_c = {k0 ^ t_c, k1 ^ k0, k2 ^ k1, k3 ^ k2};
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            round_q     <= '0;
            key_q       <= '0;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.key_valid) begin
                        key_q       <= bus.key_in;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rk_last_q   <= 1'b0;
                        if (bus.key_is_last) begin
                            state_q    <= EMIT;
                            round_q    <= LAST_ROUND;
                            rk_valid_q <= 1'b1;
                        end else begin
                            state_q    <= FWD;
                            round_q    <= '0;
                        end
                    end
                end
                FWD: begin
                    key_q   <= fwd_key_c;
                    round_q <= ROUND_W'(round_q + 4'd1);
                    if (round_q == PRE_LAST) begin
                        state_q    <= EMIT;
                        rk_valid_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.rk_ready) begin
                        if (round_q != '0) begin
                            key_q     <= inv_key_c;
                            round_q   <= ROUND_W'(round_q - 4'd1);
                            rk_last_q <= (round_q == 4'd1);
                        end else begin
                            state_q     <= IDLE;
                            rk_valid_q  <= 1'b0;
                            rk_last_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            key_ready_q <= 1'b1;
                            if (ZEROIZE) begin
                                key_q <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    round_q     <= '0;
                    key_ready_q <= 1'b1;
                    rk_valid_q  <= 1'b0;
                    rk_last_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk_data   = key_q;
    assign bus.rk_round  = round_q;
    assign bus.rk_last   = rk_last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 round keys.
module tb_aes_inv_key_sched;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_inv_key_sched_if bus ();

    aes_inv_key_sched #(.ROUNDS(10), .ZEROIZE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic         is_last;
        int           exp_edge;   // edges after accept until rk_valid is seen
        int           stall_pct;  // percent of cycles with rk_ready low
        bit           pulse_kv;   // pulse key_valid while busy
    } vec_t;

    logic [127:0] rk_exp [0:10];
    vec_t         vecs   [0:3];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rk_valid"}, 128'(bus.rk_valid), 128'd0);
        chk({tag, "_key_ready"}, 128'(bus.key_ready), 128'd1);
        chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Apply one key and collect all 11 beats against the expected table.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int r;
        int guard;
        bit rdy;
        chk({tag, "_ready_before"}, 128'(bus.key_ready), 128'd1);
        bus.key_valid   = 1'b1;
        bus.key_in      = v.key;
        bus.key_is_last = v.is_last;
        bus.rk_ready    = 1'b0;
        step();
        bus.key_valid = 1'b0;
        lat = 0;
        while (!bus.rk_valid && lat < 40) begin
            chk({tag, "_fwd_key_ready"}, 128'(bus.key_ready), 128'd0);
            chk({tag, "_fwd_busy"}, 128'(bus.busy), 128'd1);
            if (v.pulse_kv) begin
                bus.key_valid   = lat[0];
                bus.key_in      = 128'hdeadbeef_00112233_44556677_8899aabb;
                bus.key_is_last = 1'b1;
            end
            step();
            lat++;
        end
        bus.key_valid = 1'b0;
        chk({tag, "_latency"}, 128'(lat), 128'(v.exp_edge));
        r = 10;
        guard = 0;
        while (r >= 0 && guard < 400) begin
            chk({tag, "_rk_valid"}, 128'(bus.rk_valid), 128'd1);
            chk({tag, "_rk_round"}, 128'(bus.rk_round), 128'(r));
            chk({tag, "_rk_data"}, bus.rk_data, rk_exp[r]);
            chk({tag, "_rk_last"}, 128'(bus.rk_last), 128'(r == 0));
            chk({tag, "_emit_key_ready"}, 128'(bus.key_ready), 128'd0);
            rdy = (v.stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= v.stall_pct);
            bus.rk_ready = rdy;
            if (v.pulse_kv) begin
                bus.key_valid   = guard[0];
                bus.key_in      = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
                bus.key_is_last = 1'b0;
            end
            step();
            bus.key_valid = 1'b0;
            if (rdy) r--;
            guard++;
        end
        bus.rk_ready = 1'b0;
        chk({tag, "_beats_done"}, 128'(r), 128'(-1));
        chk_idle({tag, "_after"});
        chk({tag, "_zeroized"}, bus.rk_data, 128'd0);
        chk({tag, "_round_after"}, 128'(bus.rk_round), 128'd0);
        step();
        chk({tag, "_no_extra_beat"}, 128'(bus.rk_valid), 128'd0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.key_valid   = 1'b0;
        bus.key_in      = '0;
        bus.key_is_last = 1'b0;
        bus.rk_ready    = 1'b0;

        rk_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0] = '{key: rk_exp[0],  is_last: 1'b0, exp_edge: 10, stall_pct: 0,  pulse_kv: 1'b0};
        vecs[1] = '{key: rk_exp[10], is_last: 1'b1, exp_edge: 0,  stall_pct: 0,  pulse_kv: 1'b0};
        vecs[2] = '{key: rk_exp[0],  is_last: 1'b0, exp_edge: 10, stall_pct: 50, pulse_kv: 1'b1};
        vecs[3] = '{key: rk_exp[10], is_last: 1'b1, exp_edge: 0,  stall_pct: 50, pulse_kv: 1'b1};

        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset_rk_data", bus.rk_data, 128'd0);
        chk("reset_rk_round", 128'(bus.rk_round), 128'd0);
        chk("reset_rk_last", 128'(bus.rk_last), 128'd0);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while expanding forward at round 5.
        bus.key_valid   = 1'b1;
        bus.key_in      = rk_exp[0];
        bus.key_is_last = 1'b0;
        step();
        bus.key_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("fwd5_round", 128'(bus.rk_round), 128'd5);
        chk("fwd5_busy", 128'(bus.busy), 128'd1);
        do_reset();
        chk_idle("fwd5_rst");
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.rk_valid) n++;
        end
        chk("fwd5_no_beats", 128'(n), 128'd0);
        run_vec(vecs[0], "post_fwd_rst");

        // Reset while emitting round 3 under backpressure.
        bus.key_valid   = 1'b1;
        bus.key_in      = rk_exp[10];
        bus.key_is_last = 1'b1;
        step();
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b1;
        n = 0;
        while (!(bus.rk_valid && bus.rk_round == 4'd3) && n < 40) begin
            step();
            n++;
        end
        bus.rk_ready = 1'b0;
        chk("emit3_handshakes", 128'(n), 128'd7);
        step();
        chk("emit3_hold_round", 128'(bus.rk_round), 128'd3);
        chk("emit3_hold_data", bus.rk_data, rk_exp[3]);
        do_reset();
        chk_idle("emit3_rst");
        chk("emit3_rst_data", bus.rk_data, 128'd0);
        run_vec(vecs[1], "post_emit_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
